// File: rtl/window_gen_3x3_stream_if.sv
// Stream bundle for the 3x3 window generator: pixel input channel and window output channel.
interface window_gen_3x3_stream_if #(
  parameter int unsigned DW = 8
) ();
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_pixel;
  logic            out_valid;
  logic            out_ready;
  logic [9*DW-1:0] out_win;
  logic            out_sof;
  logic            out_eol;
  logic            out_eof;

  // Pixel source and window consumer side
  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_win, out_sof, out_eol, out_eof
  );

  // Window generator side
  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_win, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/window_gen_3x3_stream.sv
// Streaming 3x3 neighbourhood generator with two line buffers, optional zero padding,
// backpressure and frame markers. Window slot k = 3*dr + dc, slot 0 is top-left.
module window_gen_3x3_stream #(
  parameter int unsigned DW       = 8,
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned PAD_MODE = 0
) (
  input logic                     clk,
  input logic                     rst,
  window_gen_3x3_stream_if.slave  io_bus
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  typedef enum logic [1:0] {StRun, StEol, StFlush} state_e;

  state_e          r_state, w_state_next;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [DW-1:0]   r_lb0 [IMG_W];  // previous row
  logic [DW-1:0]   r_lb1 [IMG_W];  // row before that
  logic [DW-1:0]   r_win [9];
  logic [DW-1:0]   w_shift [9];
  logic [DW-1:0]   w_out [9];
  logic [DW-1:0]   w_col [3];
  logic            r_out_valid, r_out_sof, r_out_eol, r_out_eof;
  logic [9*DW-1:0] r_out_win, w_out_flat;
  logic            w_adv, w_accept, w_emit, w_sof, w_eol, w_eof;
  logic [CW-1:0]   w_fl_l, w_fl_r;

  // Handshake and the register window shifted by one incoming column
  always_comb begin
    w_adv    = !r_out_valid || io_bus.out_ready;
    w_accept = io_bus.in_valid && w_adv && (r_state == StRun);
    w_col[0] = r_lb1[r_col];
    w_col[1] = r_lb0[r_col];
    w_col[2] = io_bus.in_pixel;
    for (int dr = 0; dr < 3; dr++) begin
      w_shift[3*dr]   = r_win[3*dr+1];
      w_shift[3*dr+1] = r_win[3*dr+2];
      w_shift[3*dr+2] = w_col[dr];
    end
    w_fl_l = (r_col == '0) ? r_col : r_col - CW'(1);
    w_fl_r = (r_col == ColLast) ? r_col : r_col + CW'(1);
  end

  // Next state, emit decision, flags and the masked output window
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_sof        = 1'b0;
    w_eol        = 1'b0;
    w_eof        = 1'b0;
    for (int k = 0; k < 9; k++) w_out[k] = '0;
    unique case (r_state)
      StRun: begin
        for (int k = 0; k < 9; k++) w_out[k] = w_shift[k];
        if (PAD_MODE == 0) begin
          w_emit = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
          w_sof  = (r_row == RW'(2)) && (r_col == CW'(2));
          w_eol  = (r_col == ColLast);
          w_eof  = w_eol && (r_row == RowLast);
        end else begin
          w_emit = w_accept && (r_row != '0) && (r_col != '0);
          w_sof  = (r_row == RW'(1)) && (r_col == CW'(1));
          // Top row / left column lie outside the image (and may hold stale data)
          if (r_row == RW'(1)) for (int k = 0; k < 3; k++) w_out[k] = '0;
          if (r_col == CW'(1)) for (int k = 0; k < 9; k += 3) w_out[k] = '0;
          if (w_accept && (r_col == ColLast) && (r_row != '0)) w_state_next = StEol;
        end
      end
      StEol: begin
        // Last centre of the row: reuse the window shifted left, right column is padding
        w_emit = w_adv;
        w_eol  = 1'b1;
        for (int dr = 0; dr < 3; dr++) begin
          w_out[3*dr]   = r_win[3*dr+1];
          w_out[3*dr+1] = r_win[3*dr+2];
        end
        // Row counter already advanced past the triggering row; centre row 0 means r_row==2
        if (r_row == RW'(2)) for (int k = 0; k < 3; k++) w_out[k] = '0;
        if (w_adv) w_state_next = (r_row == '0) ? StFlush : StRun;
      end
      StFlush: begin
        // Last image row as centre, read straight from the line buffers; bottom row is padding
        w_emit   = w_adv;
        w_eol    = (r_col == ColLast);
        w_eof    = w_eol;
        w_out[0] = r_lb1[w_fl_l];
        w_out[3] = r_lb0[w_fl_l];
        w_out[1] = r_lb1[r_col];
        w_out[4] = r_lb0[r_col];
        w_out[2] = r_lb1[w_fl_r];
        w_out[5] = r_lb0[w_fl_r];
        if (r_col == '0) begin
          w_out[0] = '0;
          w_out[3] = '0;
        end
        if (r_col == ColLast) begin
          w_out[2] = '0;
          w_out[5] = '0;
        end
        if (w_adv && (r_col == ColLast)) w_state_next = StRun;
      end
      default: w_state_next = StRun;
    endcase
    for (int k = 0; k < 9; k++) w_out_flat[k*DW +: DW] = w_out[k];
  end

  // State, raster counters and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_win   <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (r_col == ColLast) begin
          r_col <= '0;
          r_row <= (r_row == RowLast) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      // FLUSH reuses the column counter as its position and leaves it at 0
      if ((r_state == StFlush) && w_adv) r_col <= (r_col == ColLast) ? '0 : r_col + CW'(1);
      if (w_adv) begin
        r_out_valid <= w_emit;
        r_out_sof   <= w_emit && w_sof;
        r_out_eol   <= w_emit && w_eol;
        r_out_eof   <= w_emit && w_eof;
        if (w_emit) r_out_win <= w_out_flat;
      end
    end
  end

  // Line buffers and window registers; contents need no reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= io_bus.in_pixel;
      r_win        <= w_shift;
    end
  end

  assign io_bus.in_ready  = w_adv && (r_state == StRun);
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_win   = r_out_win;
  assign io_bus.out_sof   = r_out_sof;
  assign io_bus.out_eol   = r_out_eol;
  assign io_bus.out_eof   = r_out_eof;
endmodule

// File: tb/tb_window_gen_3x3_stream.sv
// Bench for window_gen_3x3_stream: one instance per padding mode on a 4x4 image.
module tb_window_gen_3x3_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic tb_in_valid = 1'b0;
  logic [7:0] tb_in_pixel = '0;
  logic tb_out_ready = 1'b1;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [71:0] win;
    logic [2:0]  flags;  // {sof, eol, eof}
  } exp_t;

  exp_t        exp_q[$];
  logic [71:0] cap[$];
  int          bubbles;

  window_gen_3x3_stream_if #(.DW(8)) if0 ();
  window_gen_3x3_stream_if #(.DW(8)) if1 ();

  window_gen_3x3_stream #(.DW(8), .IMG_W(4), .IMG_H(4), .PAD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .io_bus(if0.slave)
  );
  window_gen_3x3_stream #(.DW(8), .IMG_W(4), .IMG_H(4), .PAD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .io_bus(if1.slave)
  );

  assign if0.in_valid  = !sel && tb_in_valid;
  assign if1.in_valid  = sel && tb_in_valid;
  assign if0.in_pixel  = tb_in_pixel;
  assign if1.in_pixel  = tb_in_pixel;
  assign if0.out_ready = sel ? 1'b1 : tb_out_ready;
  assign if1.out_ready = sel ? tb_out_ready : 1'b1;

  wire        o_in_ready  = sel ? if1.in_ready  : if0.in_ready;
  wire        o_out_valid = sel ? if1.out_valid : if0.out_valid;
  wire [71:0] o_out_win   = sel ? if1.out_win   : if0.out_win;
  wire [2:0]  o_flags     = sel ? {if1.out_sof, if1.out_eol, if1.out_eof}
                                : {if0.out_sof, if0.out_eol, if0.out_eof};

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int f, input int r, input int c);
    return (f % 2 == 1) ? 8'(255 - (16 * r + c)) : 8'(16 * r + c);
  endfunction

  function automatic logic [71:0] win9(input logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7, s8);
    return {s8, s7, s6, s5, s4, s3, s2, s1, s0};
  endfunction

  // Reference window centred at (r,c); slots outside the image are zero
  function automatic logic [71:0] model_win(input int f, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        int rr, cc;
        rr = r + dr - 1;
        cc = c + dc - 1;
        if (rr >= 0 && rr < 4 && cc >= 0 && cc < 4) w[(3*dr+dc)*8 +: 8] = pix_val(f, rr, cc);
      end
    return w;
  endfunction

  task automatic build_expected(input int mode, input int nframes);
    int lo, hi;
    exp_t e;
    lo = (mode == 0) ? 1 : 0;
    hi = (mode == 0) ? 2 : 3;
    for (int f = 0; f < nframes; f++)
      for (int r = lo; r <= hi; r++)
        for (int c = lo; c <= hi; c++) begin
          e.win   = model_win(f, r, c);
          e.flags = {(r == lo && c == lo), (c == hi), (r == hi && c == hi)};
          exp_q.push_back(e);
        end
  endtask

  // bp: 0 = always ready, 1 = ready pattern 1,0,0 repeating; gaps: random in_valid
  task automatic run_stream(input int mode, input int nframes, input int bp, input int gaps);
    int pix_idx, total, cyc;
    exp_t e;
    exp_q.delete();
    cap.delete();
    build_expected(mode, nframes);
    bubbles = 0;
    pix_idx = 0;
    total   = nframes * 16;
    cyc     = 0;
    sel     = (mode != 0);
    while ((pix_idx < total || exp_q.size() > 0) && cyc < 600) begin
      @(negedge clk);
      tb_in_valid  = (pix_idx < total) && (gaps == 0 || $urandom_range(0, 1) == 1);
      tb_in_pixel  = pix_val(pix_idx / 16, (pix_idx % 16) / 4, pix_idx % 4);
      tb_out_ready = (bp == 0) || (cyc % 3 == 0);
      #1;
      if (o_out_valid) begin
        if (exp_q.size() == 0) begin
          check_value("extra_window", o_out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          check_value("win", o_out_win, e.win);
          check_value("flags", o_flags, e.flags);
          if (tb_out_ready) begin
            cap.push_back(o_out_win);
            void'(exp_q.pop_front());
          end else begin
            check_value("in_ready_stall", o_in_ready, 1'b0);
          end
        end
      end
      if (pix_idx > 0 && pix_idx < total && !o_in_ready) bubbles++;
      if (tb_in_valid && o_in_ready) pix_idx++;
      cyc++;
    end
    check_value("budget", (pix_idx == total) && (exp_q.size() == 0), 1'b1);
    // No further windows once the frame is drained
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tb_in_valid  = 1'b0;
      tb_out_ready = 1'b1;
      #1;
      check_value("idle_valid", o_out_valid, 1'b0);
    end
  endtask

  task automatic feed_partial(input int mode, input int n);
    int cnt, cyc;
    cnt = 0;
    cyc = 0;
    sel = (mode != 0);
    while (cnt < n && cyc < 100) begin
      @(negedge clk);
      tb_in_valid  = 1'b1;
      tb_in_pixel  = pix_val(0, cnt / 4, cnt % 4);
      tb_out_ready = 1'b1;
      #1;
      if (o_in_ready) cnt++;
      cyc++;
    end
    check_value("partial_budget", cnt, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tb_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("rst_valid0", if0.out_valid, 1'b0);
    check_value("rst_valid1", if1.out_valid, 1'b0);
    check_value("rst_win0", if0.out_win, 72'h0);
    check_value("rst_flags1", {if1.out_sof, if1.out_eol, if1.out_eof}, 3'b000);
    check_value("rst_ready0", if0.in_ready, 1'b1);
    check_value("rst_ready1", if1.in_ready, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // Valid-only, full speed
    run_stream(0, 1, 0, 0);
    check_value("t1_count", cap.size(), 4);
    if (cap.size() == 4) begin
      check_value("t1_first", cap[0], win9(0, 1, 2, 16, 17, 18, 32, 33, 34));
      check_value("t1_last", cap[3], win9(17, 18, 19, 33, 34, 35, 49, 50, 51));
    end
    check_value("t1_bubbles", bubbles, 0);

    // Zero-pad, full speed: one bubble after rows 1 and 2
    run_stream(1, 1, 0, 0);
    check_value("t2_count", cap.size(), 16);
    if (cap.size() == 16) begin
      check_value("t2_first", cap[0], win9(0, 0, 0, 0, 0, 1, 0, 16, 17));
      check_value("t2_row0_end", cap[3], win9(0, 0, 0, 2, 3, 0, 18, 19, 0));
      check_value("t2_last", cap[15], win9(34, 35, 0, 50, 51, 0, 0, 0, 0));
    end
    check_value("t2_bubbles", bubbles, 2);

    // Backpressure
    run_stream(1, 1, 1, 0);
    check_value("t3_count", cap.size(), 16);

    // Back-to-back frames, second frame inverted
    run_stream(0, 2, 0, 0);
    check_value("t4_pad0_bubbles", bubbles, 0);
    run_stream(1, 2, 0, 0);
    check_value("t4_pad1_bubbles", bubbles, 9);
    if (cap.size() == 32)
      check_value("t4_f2_first", cap[16], win9(0, 0, 0, 0, 255, 254, 0, 239, 238));

    // Mid-frame reset drops the partial frame
    feed_partial(0, 7);
    do_reset();
    run_stream(0, 1, 0, 0);
    if (cap.size() == 4)
      check_value("t5_pad0_first", cap[0], win9(0, 1, 2, 16, 17, 18, 32, 33, 34));
    feed_partial(1, 7);
    do_reset();
    run_stream(1, 1, 0, 0);
    if (cap.size() == 16)
      check_value("t5_pad1_first", cap[0], win9(0, 0, 0, 0, 0, 1, 0, 16, 17));

    // Random input gaps, plus gaps combined with backpressure
    run_stream(0, 1, 0, 1);
    run_stream(1, 1, 0, 1);
    run_stream(1, 2, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
